// File: rtl/scc_pkg.sv
// Shared constants, types and wave-RAM indexing for the SCC/SCC+ sound block.
// SCC_PLUS_EN selects the SCC+ register map and an independent channel-4 wave.
package scc_pkg;
   localparam int CH_NUM     = 5;
   localparam int WAVE_LEN   = 32;
   localparam int MIX_W      = 15;
   localparam int MIN_FREQ   = 9;
`ifdef SCC_PLUS_EN
   localparam bit PLUS_EN    = 1'b1;
   localparam int WAVE_BYTES = 160;
`else
   localparam bit PLUS_EN    = 1'b0;
   localparam int WAVE_BYTES = 128;
`endif
   localparam int WAVE_AW    = $clog2(WAVE_BYTES);

   // Window offsets, SCC map then SCC+ map
   localparam logic [7:0] SCC_REG      = 8'h80;
   localparam logic [7:0] SCC_WAVE4_RD = 8'hA0;
   localparam logic [7:0] SCC_RSVD     = 8'hC0;
   localparam logic [7:0] SCC_DEFORM   = 8'hE0;
   localparam logic [7:0] PLUS_REG     = 8'hA0;
   localparam logic [7:0] PLUS_DEFORM  = 8'hC0;
   localparam logic [7:0] PLUS_RSVD    = 8'hE0;

   typedef enum logic [1:0] {IDLE, ACC, DONE} mix_state_t;
   typedef logic [2:0] chan_idx_t;

   // Without an independent ch4 wave, ch4 reads the ch3 bytes.
   function automatic logic [WAVE_AW-1:0] wave_index(chan_idx_t ch, logic [4:0] ptr);
      chan_idx_t eff;
      eff = (!PLUS_EN && ch == 3'd4) ? 3'd3 : ch;
      return WAVE_AW'({eff, ptr});
   endfunction
endpackage

// File: rtl/scc_sound_if.sv
// CPU-side bus of the SCC responder: window select, strobes, address/data, map mode.
interface scc_sound_if;
   logic       req;
   logic       wr;
   logic       rd;
   logic       plus_mode;
   logic [7:0] addr;
   logic [7:0] din;
   logic [7:0] dout;

   modport master (output req, wr, rd, plus_mode, addr, din, input dout);
   modport slave  (input req, wr, rd, plus_mode, addr, din, output dout);
endinterface

// File: rtl/scc_channel.sv
// One SCC wave channel: 12-bit period down-counter and 5-bit wave pointer.
module scc_channel
   import scc_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_ce,
   input  logic        i_freq_wr,
   input  logic [11:0] i_freq,
   input  logic        i_deform_rst,
   output logic [11:0] o_freq,
   output logic [4:0]  o_ptr
);
   logic [11:0] r_freq;
   logic [11:0] r_count;
   logic [4:0]  r_ptr;

   // A frequency write outranks a coincident tick; periods below MIN_FREQ halt the channel.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_freq  <= '0;
         r_count <= '0;
         r_ptr   <= '0;
      end else if (i_freq_wr) begin
         r_freq  <= i_freq;
         r_count <= i_freq;
         if (i_deform_rst) r_ptr <= '0;
      end else if (i_ce && r_freq >= 12'(MIN_FREQ)) begin
         if (r_count == '0) begin
            r_count <= r_freq;
            r_ptr   <= r_ptr + 5'd1;
         end else begin
            r_count <= r_count - 12'd1;
         end
      end
   end

   assign o_freq = r_freq;
   assign o_ptr  = r_ptr;
endmodule

// File: rtl/scc_sound.sv
// SCC/SCC+ wavetable responder: address decode, wave RAM, registers, 5-channel mixer.
// Build option SCC_PLUS_EN enables the SCC+ map; otherwise plus_mode is ignored.
module scc_sound
   import scc_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ce,
   scc_sound_if.slave            bus,
   output logic signed [MIX_W-1:0] sound
);
   logic               w_plus, w_wr_en, w_rd_en, w_unused;
   logic               w_wave_wr, w_wave_wr4, w_rd_wave, w_reg_sel, w_deform_sel;
   logic [WAVE_AW-1:0] w_wave_idx, w_wave_idx4, w_rd_idx;
   logic [3:0]         w_reg_off;
   logic [7:0]         r_wave [WAVE_BYTES];
   logic [3:0]         r_vol [CH_NUM];
   logic [CH_NUM-1:0]  r_enable;
   logic [7:0]         r_deform;
   logic [CH_NUM-1:0]  w_freq_wr;
   logic [11:0]        w_freq_new [CH_NUM];
   logic [11:0]        w_freq_cur [CH_NUM];
   logic [4:0]         w_ptr [CH_NUM];
   mix_state_t         r_state;
   chan_idx_t          r_mix_idx;
   logic signed [MIX_W-1:0] r_acc, w_term;
   logic [7:0]         w_sample;
   logic signed [12:0] w_sample_x, w_vol_x, w_prod;

`ifdef SCC_PLUS_EN
   assign w_plus = bus.plus_mode;
`else
   assign w_plus = 1'b0;
`endif
   assign w_unused  = ^{bus.plus_mode, r_deform[7:6], r_deform[4:0]};
   assign w_wr_en   = bus.req & bus.wr;
   assign w_rd_en   = bus.req & bus.rd & ~bus.wr;
   assign w_reg_off = bus.addr[3:0];

   always_comb begin
      w_wave_wr    = 1'b0;
      w_wave_wr4   = 1'b0;
      w_rd_wave    = 1'b0;
      w_reg_sel    = 1'b0;
      w_deform_sel = 1'b0;
      w_wave_idx   = WAVE_AW'(bus.addr[6:0]);
      w_wave_idx4  = wave_index(3'd4, bus.addr[4:0]);
      w_rd_idx     = WAVE_AW'(bus.addr[6:0]);
      if (!w_plus) begin
         if (bus.addr < SCC_REG) begin
            w_wave_wr  = 1'b1;
            w_rd_wave  = 1'b1;
            w_wave_wr4 = PLUS_EN && (bus.addr >= 8'h60);
         end else if (bus.addr < SCC_WAVE4_RD) begin
            w_reg_sel = 1'b1;
         end else if (bus.addr < SCC_RSVD) begin
            w_rd_wave = 1'b1;
            w_rd_idx  = w_wave_idx4;
         end else if (bus.addr >= SCC_DEFORM) begin
            w_deform_sel = 1'b1;
         end
      end else begin
         if (bus.addr < PLUS_REG) begin
            w_wave_wr  = 1'b1;
            w_rd_wave  = 1'b1;
            w_wave_idx = WAVE_AW'(bus.addr);
            w_rd_idx   = WAVE_AW'(bus.addr);
         end else if (bus.addr < PLUS_DEFORM) begin
            w_reg_sel = 1'b1;
         end else if (bus.addr < PLUS_RSVD) begin
            w_deform_sel = 1'b1;
         end
      end
   end

   // Register offsets 0-9 are lo/hi frequency pairs; hi keeps only din[3:0].
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         w_freq_wr[i]  = w_wr_en && w_reg_sel && (w_reg_off < 4'd10) && (w_reg_off[3:1] == 3'(i));
         w_freq_new[i] = w_reg_off[0] ? {bus.din[3:0], w_freq_cur[i][7:0]}
                                      : {w_freq_cur[i][11:8], bus.din};
      end
   end

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      scc_channel u_ch (
         .clk          (clk),
         .reset_n      (reset_n),
         .i_ce         (ce),
         .i_freq_wr    (w_freq_wr[g]),
         .i_freq       (w_freq_new[g]),
         .i_deform_rst (r_deform[5]),
         .o_freq       (w_freq_cur[g]),
         .o_ptr        (w_ptr[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < WAVE_BYTES; i++) r_wave[i] <= '0;
         for (int i = 0; i < CH_NUM; i++) r_vol[i] <= '0;
         r_enable <= '0;
         r_deform <= '0;
      end else if (w_wr_en) begin
         if (w_wave_wr)    r_wave[w_wave_idx]  <= bus.din;
         if (w_wave_wr4)   r_wave[w_wave_idx4] <= bus.din;
         if (w_deform_sel) r_deform            <= bus.din;
         if (w_reg_sel) begin
            case (w_reg_off)
               4'hA:    r_vol[0] <= bus.din[3:0];
               4'hB:    r_vol[1] <= bus.din[3:0];
               4'hC:    r_vol[2] <= bus.din[3:0];
               4'hD:    r_vol[3] <= bus.din[3:0];
               4'hE:    r_vol[4] <= bus.din[3:0];
               4'hF:    r_enable <= bus.din[4:0];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)                   bus.dout <= 8'hFF;
      else if (w_rd_en && w_rd_wave)  bus.dout <= r_wave[w_rd_idx];
      else                            bus.dout <= 8'hFF;
   end

   assign w_sample   = r_wave[wave_index(r_mix_idx, w_ptr[r_mix_idx])];
   assign w_sample_x = {{5{w_sample[7]}}, w_sample};
   assign w_vol_x    = {9'd0, r_vol[r_mix_idx]};
   assign w_prod     = w_sample_x * w_vol_x;
   assign w_term     = r_enable[r_mix_idx] ? {{(MIX_W-13){w_prod[12]}}, w_prod} : '0;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_mix_idx <= '0;
         r_acc     <= '0;
         sound     <= '0;
      end else begin
         case (r_state)
            IDLE: if (ce) begin
               r_state   <= ACC;
               r_mix_idx <= '0;
               r_acc     <= '0;
            end
            ACC: begin
               r_acc <= r_acc + w_term;
               if (r_mix_idx == 3'(CH_NUM - 1)) r_state <= DONE;
               else                             r_mix_idx <= r_mix_idx + 3'd1;
            end
            DONE: begin
               sound   <= r_acc;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_scc_sound.sv
// Directed bench for scc_sound: decode, readback, aliasing, channel timing, mixer.
module tb_scc_sound;
   import scc_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic ce = 1'b0;
   logic signed [14:0] sound;
   int n_cmp = 0;
   int n_err = 0;

   scc_sound_if bus();

   scc_sound dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ce      (ce),
      .bus     (bus),
      .sound   (sound)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.req = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.plus_mode = 1'b0;
      ce = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.req = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.din = d;
      @(negedge clk);
      bus.req = 1'b0; bus.wr = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
      @(negedge clk);
      bus.req = 1'b1; bus.rd = 1'b1; bus.addr = a;
      @(posedge clk);
      #1 d = bus.dout;
      @(negedge clk);
      bus.req = 1'b0; bus.rd = 1'b0;
   endtask

   task automatic pulse_ce();
      @(negedge clk);
      ce = 1'b1;
      @(negedge clk);
      ce = 1'b0;
   endtask

   // ch0 wave byte k = k+1, so a one-volume mix reads back pointer+1
   task automatic ramp_ch0();
      for (int k = 0; k < 32; k++) bus_write(8'(k), 8'(k + 1));
      bus_write(8'h8A, 8'h01);
      bus_write(8'h8F, 8'h01);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      do_reset();
      #1;
      n_cmp++;
      if (bus.dout !== 8'hFF) begin n_err++; $display("FAIL reset_dout: got %h expected ff", bus.dout); end
      n_cmp++;
      if (sound !== 15'sd0) begin n_err++; $display("FAIL reset_sound: got %0d expected 0", sound); end
      bus_read(8'h00, d);
      n_cmp++;
      if (d !== 8'h00) begin n_err++; $display("FAIL reset_wave_read: got %h expected 00", d); end
   endtask

   task automatic test_single_tone();
      do_reset();
      for (int k = 0; k < 32; k++) bus_write(8'(k), 8'h7F);
      bus_write(8'h8A, 8'h0F);
      bus_write(8'h80, 8'h20);
      bus_write(8'h81, 8'h00);
      bus_write(8'h8F, 8'h01);
      pulse_ce();
      repeat (5) @(posedge clk);
      #1;
      n_cmp++;
      if (sound !== 15'sd0) begin n_err++; $display("FAIL tone_early: got %0d expected 0", sound); end
      @(posedge clk);
      #1;
      n_cmp++;
      if (int'(sound) !== 1905) begin n_err++; $display("FAIL tone_sound: got %0d expected 1905", sound); end
   endtask

   task automatic test_reset_mid_mix();
      pulse_ce();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (dut.r_state !== ACC) begin n_err++; $display("FAIL midmix_in_acc: got %0d expected %0d", dut.r_state, ACC); end
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (sound !== 15'sd0) begin n_err++; $display("FAIL midmix_sound: got %0d expected 0", sound); end
      n_cmp++;
      if (dut.r_state !== IDLE) begin n_err++; $display("FAIL midmix_state: got %0d expected %0d", dut.r_state, IDLE); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_mix_multi();
      do_reset();
      bus_write(8'h00, 8'h7F);
      bus_write(8'h20, 8'h80);
      bus_write(8'h8A, 8'h0F);
      bus_write(8'h8B, 8'h0F);
      bus_write(8'h8F, 8'h03);
      pulse_ce(); repeat (7) @(posedge clk); #1;
      n_cmp++;
      if (int'(sound) !== -15) begin n_err++; $display("FAIL mix_two: got %0d expected -15", sound); end
      bus_write(8'h8F, 8'h02);
      pulse_ce(); repeat (7) @(posedge clk); #1;
      n_cmp++;
      if (int'(sound) !== -1920) begin n_err++; $display("FAIL mix_neg: got %0d expected -1920", sound); end
      bus_write(8'h00, 8'h80);
      bus_write(8'h40, 8'h80);
      bus_write(8'h60, 8'h80);
      bus_write(8'h8C, 8'hFF);
      bus_write(8'h8D, 8'h0F);
      bus_write(8'h8E, 8'h0F);
      bus_write(8'h8F, 8'h1F);
      pulse_ce(); repeat (7) @(posedge clk); #1;
      n_cmp++;
      if (int'(sound) !== -9600) begin n_err++; $display("FAIL mix_full: got %0d expected -9600", sound); end
   endtask

   task automatic test_period();
      int exp;
      do_reset();
      ramp_ch0();
      bus_write(8'h80, 8'h09);
      bus_write(8'h81, 8'h00);
      for (int n = 1; n <= 20; n++) begin
         pulse_ce(); repeat (7) @(posedge clk); #1;
         if (n == 9 || n == 10 || n == 19 || n == 20) begin
            exp = (n < 10) ? 1 : ((n < 20) ? 2 : 3);
            n_cmp++;
            if (int'(sound) !== exp) begin n_err++; $display("FAIL period_ce%0d: got %0d expected %0d", n, sound, exp); end
         end
      end
      bus_write(8'h80, 8'h05);
      for (int n = 0; n < 12; n++) begin
         pulse_ce(); repeat (7) @(posedge clk);
      end
      #1;
      n_cmp++;
      if (int'(sound) !== 3) begin n_err++; $display("FAIL halted_freq5: got %0d expected 3", sound); end
   endtask

   task automatic test_deform();
      do_reset();
      ramp_ch0();
      bus_write(8'hE0, 8'h20);
      bus_write(8'h80, 8'h09);
      for (int n = 0; n < 100; n++) begin
         pulse_ce(); repeat (7) @(posedge clk);
      end
      #1;
      n_cmp++;
      if (int'(sound) !== 11) begin n_err++; $display("FAIL deform_run: got %0d expected 11", sound); end
      bus_write(8'h80, 8'h09);
      pulse_ce(); repeat (7) @(posedge clk); #1;
      n_cmp++;
      if (int'(sound) !== 1) begin n_err++; $display("FAIL deform_ptr_rst: got %0d expected 1", sound); end
   endtask

   task automatic test_alias();
      logic [7:0] d;
      logic [7:0] exp80, expa0;
`ifdef SCC_PLUS_EN
      exp80 = 8'h55; expa0 = 8'h55;
`else
      exp80 = 8'hFF; expa0 = 8'h11;
`endif
      do_reset();
      bus_write(8'h60, 8'h55);
      bus_read(8'hA0, d);
      n_cmp++;
      if (d !== 8'h55) begin n_err++; $display("FAIL alias_a0: got %h expected 55", d); end
      bus.plus_mode = 1'b1;
      bus_write(8'h60, 8'h11);
      bus_read(8'h60, d);
      n_cmp++;
      if (d !== 8'h11) begin n_err++; $display("FAIL plus_60: got %h expected 11", d); end
      bus_read(8'h80, d);
      n_cmp++;
      if (d !== exp80) begin n_err++; $display("FAIL plus_80: got %h expected %h", d, exp80); end
      bus.plus_mode = 1'b0;
      bus_read(8'hA0, d);
      n_cmp++;
      if (d !== expa0) begin n_err++; $display("FAIL back_a0: got %h expected %h", d, expa0); end
   endtask

   task automatic test_mirror();
      logic [7:0] d;
      do_reset();
      bus_write(8'h90, 8'h20);
      n_cmp++;
      if (dut.g_ch[0].u_ch.r_freq !== 12'h020) begin n_err++; $display("FAIL mirror_lo: got %h expected 020", dut.g_ch[0].u_ch.r_freq); end
      bus_write(8'h91, 8'hF3);
      n_cmp++;
      if (dut.g_ch[0].u_ch.r_freq !== 12'h320) begin n_err++; $display("FAIL mirror_hi: got %h expected 320", dut.g_ch[0].u_ch.r_freq); end
      bus_read(8'h80, d);
      n_cmp++;
      if (d !== 8'hFF) begin n_err++; $display("FAIL read_80: got %h expected ff", d); end
      bus_read(8'hE0, d);
      n_cmp++;
      if (d !== 8'hFF) begin n_err++; $display("FAIL read_e0: got %h expected ff", d); end
      bus_read(8'hC0, d);
      n_cmp++;
      if (d !== 8'hFF) begin n_err++; $display("FAIL read_c0: got %h expected ff", d); end
   endtask

   task automatic test_rd_wr();
      logic [7:0] d;
      do_reset();
      @(negedge clk);
      bus.req = 1'b1; bus.rd = 1'b1; bus.wr = 1'b1; bus.addr = 8'h05; bus.din = 8'h5A;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.dout !== 8'hFF) begin n_err++; $display("FAIL rdwr_dout: got %h expected ff", bus.dout); end
      @(negedge clk);
      bus.req = 1'b0; bus.wr = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.dout !== 8'hFF) begin n_err++; $display("FAIL rd_noreq: got %h expected ff", bus.dout); end
      @(negedge clk);
      bus.rd = 1'b0;
      bus_read(8'h05, d);
      n_cmp++;
      if (d !== 8'h5A) begin n_err++; $display("FAIL rdwr_written: got %h expected 5a", d); end
   endtask

   initial begin
      bus.req = 1'b0; bus.wr = 1'b0; bus.rd = 1'b0; bus.plus_mode = 1'b0;
      bus.addr = 8'h00; bus.din = 8'h00;
      test_reset();
      test_single_tone();
      test_reset_mid_mix();
      test_mix_multi();
      test_period();
      test_deform();
      test_alias();
      test_mirror();
      test_rd_wr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
